// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
// Bundles the data/control inputs and display outputs of the seven-segment
// scan driver.
//   digits_in  : hex digit k on bits [4k+3:4k]
//   dp_in      : decimal point request per digit
//   blank_in   : force digit k dark (segments and dp)
//   load       : one-cycle strobe, capture digits_in/dp_in/blank_in to shadow
//   brightness : 0 = off, all-ones = full on
//   seg        : segments {g,f,e,d,c,b,a}
//   dp         : decimal point segment
//   an         : digit enables, one-hot when active
//   digit_idx  : digit currently scanned
//   frame_tick : one-cycle pulse when the scan wraps back to digit 0
// Handshake: load is a plain strobe with no ready; every cycle load=1 is
// sampled is a capture. The driver never back-pressures.
// master = producer of data (time-keeping logic / bench), slave = driver.
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic [BRIGHT_W-1:0]     brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;

  modport master (
    output digits_in, dp_in, blank_in, load, brightness,
    input  seg, dp, an, digit_idx, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, blank_in, load, brightness,
    output seg, dp, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
// Time-multiplexed seven-segment driver: scans NUM_DIGITS digits, decodes hex,
// supports per-digit blanking, decimal points, leading-zero suppression and
// PWM brightness. New data is double-buffered (shadow -> active) and only
// takes effect at the frame wrap, so the display never tears.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : sevenseg_scan_driver_if.slave (data in, display pins out)
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_scan_driver_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    DIG_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PWM_MAX  = BRIGHT_W'((1 << BRIGHT_W) - 2);
  localparam logic                POL      = (ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
    endcase
  endfunction

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        digit_q, digit_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic                    pending_q, pending_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    slot_end, frame_end, lit;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_lz, zero_run;
  logic [NUM_DIGITS-1:0]   lz_vec;

  assign slot_end  = (presc_q == PRE_LAST);
  assign frame_end = slot_end && (digit_q == DIG_LAST);

  // Scan counters, double buffer and brightness sampling.
  always_comb begin
    presc_d      = slot_end ? '0 : presc_q + 1'b1;
    digit_d      = digit_q;
    if (slot_end) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    frame_tick_d = frame_end;

    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    pending_d  = pending_q;
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;

    // The active set takes the shadow as it stood before this edge; a load
    // on the wrap edge itself lands in the shadow and waits a full frame.
    if (frame_end) begin
      pending_d = 1'b0;
      if (pending_q) begin
        act_dig_d   = sh_dig_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
      end
    end
    if (bus.load) begin
      sh_dig_d   = bus.digits_in;
      sh_dp_d    = bus.dp_in;
      sh_blank_d = bus.blank_in;
      pending_d  = 1'b1;
    end

    bright_d = (presc_q == '0) ? bus.brightness : bright_q;
    pwm_d    = (pwm_q == PWM_MAX) ? '0 : pwm_q + 1'b1;
  end

  // Leading-zero suppression: walk down from the top digit while all seen are 0.
  always_comb begin
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run  = zero_run && (act_dig_q[4*k +: 4] == 4'h0);
      lz_vec[k] = zero_run && (k != 0) && (LZ_BLANK != 0);
    end
  end

  // Select the scanned digit and build the registered pin values.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_d      = {NUM_DIGITS{POL}};
    // Prescaler 0 is kept dark as the ghosting guard between digits.
    lit = (pwm_q < bright_q) && (presc_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == IDX_W'(k)) begin
        cur_nib   = act_dig_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = act_blank_q[k];
        cur_lz    = lz_vec[k];
        an_d[k]   = lit ^ POL;
      end
    end
    seg_d = ((lit && !cur_blank && !cur_lz) ? hex_decode(cur_nib) : 7'h00) ^ {7{POL}};
    dp_d  = (lit && cur_dp && !cur_blank) ^ POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= '0;
      frame_tick_q <= 1'b0;
      sh_dig_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pending_q    <= 1'b0;
      bright_q     <= '0;
      pwm_q        <= '0;
      seg_q        <= {7{POL}};
      dp_q         <= POL;
      an_q         <= {NUM_DIGITS{POL}};
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      frame_tick_q <= frame_tick_d;
      sh_dig_q     <= sh_dig_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pending_q    <= pending_d;
      bright_q     <= bright_d;
      pwm_q        <= pwm_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = digit_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
// Directed bench for the seven-segment scan driver. dut_a (SCAN_DIV=4) covers
// decode, scan order, double buffering, blanking, dp and reset; dut_b
// (SCAN_DIV=30, brightness 5) covers the PWM duty cycle.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(4), .BRIGHT_W(4)) bus_a ();
  sevenseg_scan_driver_if #(.NUM_DIGITS(4), .BRIGHT_W(4)) bus_b ();

  sevenseg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BRIGHT_W(4),
                         .ACTIVE_LOW(1), .LZ_BLANK(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  sevenseg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(30), .BRIGHT_W(4),
                         .ACTIVE_LOW(1), .LZ_BLANK(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    @(negedge clk);
    bus_a.digits_in = d;
    bus_a.dp_in     = dpv;
    bus_a.blank_in  = bl;
    bus_a.load      = 1'b1;
    @(negedge clk);
    bus_a.load      = 1'b0;
  endtask

  // Advance to the next negedge on which frame_tick is high (bounded).
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_a.frame_tick !== 1'b1 && n < 40);
    chk("frame_tick_timeout", {31'd0, bus_a.frame_tick}, 32'd1);
  endtask

  // Called on a frame_tick negedge; checks all 16 output cycles of the frame
  // just started and ends on the next frame_tick negedge.
  // exp_seg is {digit3,digit2,digit1,digit0} active-low segment codes.
  task automatic check_frame(input logic [27:0] exp_seg, input logic [3:0] exp_dp_on);
    int st, k, p;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      bus_a.load = 1'b0;  // end any load pulse started on the frame_tick cycle
      st = j - 1;
      k  = st / 4;
      p  = st % 4;
      if (p == 0) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << k);
        e_seg = exp_seg[7*k +: 7];
        e_dp  = ~exp_dp_on[k];
      end
      chk($sformatf("an j=%0d", j),  {28'd0, bus_a.an}, {28'd0, e_an});
      chk($sformatf("seg j=%0d", j), {25'd0, bus_a.seg}, {25'd0, e_seg});
      chk($sformatf("dp j=%0d", j),  {31'd0, bus_a.dp}, {31'd0, e_dp});
      chk($sformatf("digit_idx j=%0d", j), {30'd0, bus_a.digit_idx}, 32'((j / 4) % 4));
      chk($sformatf("frame_tick j=%0d", j), {31'd0, bus_a.frame_tick}, (j == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int cnt;
    bus_a.digits_in = '0; bus_a.dp_in = '0; bus_a.blank_in = '0;
    bus_a.load = 1'b0;    bus_a.brightness = 4'hF;
    bus_b.digits_in = '0; bus_b.dp_in = '0; bus_b.blank_in = '0;
    bus_b.load = 1'b0;    bus_b.brightness = 4'h5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an",  {28'd0, bus_a.an}, 32'hF);
    chk("rst_seg", {25'd0, bus_a.seg}, 32'h7F);
    chk("rst_dp",  {31'd0, bus_a.dp}, 32'd1);
    chk("rst_idx", {30'd0, bus_a.digit_idx}, 32'd0);
    chk("rst_ft",  {31'd0, bus_a.frame_tick}, 32'd0);
    rst = 1'b0;

    // PWM duty: presc period 30, pwm period 15, both start together, so per
    // 30 cycles pwm<5 on 10 cycles minus the one at presc=0 -> 9; 300 -> 90.
    repeat (40) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_b.an !== 4'hF) cnt++;
    end
    chk("pwm_b5_lit_cycles", cnt, 32'd90);

    // Decode and scan order
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_frame();
    check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);

    // Leading-zero suppression
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0000);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);

    // dp and blanking
    do_load(16'h8888, 4'b0010, 4'b0100);
    wait_frame();
    check_frame({7'h00, 7'h7F, 7'h00, 7'h00}, 4'b0010);

    // Last load in a frame wins; a load on the frame_tick cycle waits a frame
    wait_frame();
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h5555, 4'b0000, 4'b0000);
    wait_frame();
    bus_a.digits_in = 16'hFFFF;
    bus_a.load      = 1'b1;
    check_frame({7'h12, 7'h12, 7'h12, 7'h12}, 4'b0000);
    check_frame({7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000);

    // Brightness 0: anodes never active
    bus_a.brightness = 4'h0;
    wait_frame();
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_a.an !== 4'hF) cnt++;
    end
    chk("bright0_an_active_cycles", cnt, 32'd0);
    bus_a.brightness = 4'hF;
    wait_frame();
    wait_frame();

    // Reset mid-slot discards the pending load
    do_load(16'h1234, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an",  {28'd0, bus_a.an}, 32'hF);
    chk("midrst_idx", {30'd0, bus_a.digit_idx}, 32'd0);
    chk("midrst_ft",  {31'd0, bus_a.frame_tick}, 32'd0);
    chk("midrst_seg", {25'd0, bus_a.seg}, 32'h7F);
    rst = 1'b0;
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
